alu_arbiter: RTL
================

# alu_arbiter

Two-port round-robin arbiter and sequencer that shares the core's single combinational `alu` between two requesters, for example the EX stage and a multi-cycle helper unit. It accepts operations over valid/ready handshakes and drives the shared ALU's `op1`/`op2`/`sel` from the granted request. It captures `res` into a per-requester registered response slot with its own valid/ready handshake. Aggregate throughput is one ALU operation per cycle; latency is one cycle from acceptance to response.

## Interface
- `DATA_W`, 32, operand and result width
- `SEL_W`, 5, ALU select width; encodings: ADD 0, SLL 1, SLT 2, SLTU 3, XOR 4, SRL 5, OR 6, AND 7, SUB 8, B (pass op2) 9, SRA 13; all others produce 0
- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: asynchronous assert, active-low reset
- `reqN_valid` in 1 (N = 0, 1): request N presents an operation
- `reqN_ready` out 1: request N accepted this cycle
- `reqN_op1`, `reqN_op2` in DATA_W: operands
- `reqN_sel` in SEL_W: ALU select
- `respN_valid` out 1: response slot N holds a result
- `respN_ready` in 1: requester N consumes the response
- `respN_data` out DATA_W: registered result
- `alu_op1`, `alu_op2` out DATA_W: to shared ALU
- `alu_sel` out SEL_W: to shared ALU
- `alu_res` in DATA_W: combinational result from shared ALU
- `prio` out 1: current round-robin priority (0 = req0 wins ties); for debug/verification

## Operation
- Eligibility: `eligN = reqN_valid && (!respN_valid || respN_ready)`. A requester whose slot is full and not draining this cycle is never granted.
- Grant, combinational:
  - both eligible: grant `prio`
  - one eligible: grant it
  - none: no grant
- `reqN_ready = grantN`; at most one of `req0_ready`/`req1_ready` is high in any cycle.
- ALU drive:
  - granted: granted requester's op1/op2/sel
  - idle: `alu_op1 = 0`, `alu_op2 = 0`, `alu_sel = 0` (ADD)
- Priority update on any grant: `prio <= ~granted_id`. With no grant, `prio` holds.
- Slot N at each clock edge:
  - if `grantN`: `respN_data <= alu_res`, `respN_valid <= 1`
  - else if `respN_valid && respN_ready`: `respN_valid <= 0`, data holds
  - else: hold
- Grant and drain in the same cycle on the same slot: the new result replaces the old and valid stays 1, giving back-to-back throughput.
- Illegal `sel`: passed through unchanged; the result is whatever the ALU returns (0). No error flag.
- Requester obligation: `reqN_op1`/`op2`/`sel` must be stable while `reqN_valid && !reqN_ready`. The arbiter does not latch unaccepted requests.
- Fairness: a continuously eligible requester is granted within 2 cycles.

## Timing
- Reset (async, `rst_n` low): `resp0_valid`/`resp1_valid` = 0, `resp0_data`/`resp1_data` = 0, `prio` = 0. `reqN_ready` = 0 and ALU outputs read 0 while `rst_n` is low.
- Reset mid-operation: any captured but unconsumed response is discarded. An operation granted in the cycle reset asserts is lost, and the requester must reissue it.
- Deassertion of `rst_n` is synchronised externally. The first grant is possible in the first cycle after release.
- Accept in cycle C (valid && ready at edge C) means `respN_valid = 1` and `respN_data` = result from cycle C+1.
- Combinational paths:
  - `respN_ready` → `reqN_ready`
  - `reqN_*` → `alu_*`
  - `alu_res` → slot D-input
- The ALU is not registered. The full path from `reqN_op*` through `alu` to the slot must meet one cycle.
- Both requesters streaming with free slots: grants alternate 0,1,0,1..., one per cycle.

## Test plan
- Single op: req0 ADD, op1=5, op2=7 → `req0_ready`=1 same cycle; next cycle `resp0_valid`=1, `resp0_data`=12; `prio`=1.
- Tie after reset: req0 SUB 10-3 and req1 XOR 0xF0^0xFF both valid → cycle 0 grants req0 (resp0=7); cycle 1 grants req1 (resp1=0x0F); then strict alternation over 8 cycles with 4 grants each.
- Backpressure: req0 SLL 1<<4 accepted, `resp0_ready`=0 held 3 cycles, req0 reissues AND → `req0_ready` stays 0 and `resp0_data` holds 16. Raise `resp0_ready` → same-cycle grant; next cycle shows the AND result with `resp0_valid` never dropping.
- Blocked slot does not starve the other side: resp0 full and stalled, req1 SRA 0x80000000>>>4 → granted immediately; `resp1_data`=0xF8000000.
- Select coverage: each legal sel on op1=0xFFFFFFFE, op2=1 → ADD 0xFFFFFFFF, SLT 1, SLTU 0, B 1; sel=20 → 0.
- Async reset mid-stream: pull `rst_n` low between edges with both slots valid → valids and data go to 0 immediately, `prio`=0. After release, tied requests grant req0 first.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Handshake and shared-ALU bundle between the arbiter and its environment.
// The slave side is the arbiter. The master side is the two requesters
// together with the shared combinational ALU.
interface alu_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 5
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_op1;
    logic [DATA_W-1:0] req0_op2;
    logic [SEL_W-1:0]  req0_sel;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_op1;
    logic [DATA_W-1:0] req1_op2;
    logic [SEL_W-1:0]  req1_sel;

    logic              resp0_valid;
    logic              resp0_ready;
    logic [DATA_W-1:0] resp0_data;

    logic              resp1_valid;
    logic              resp1_ready;
    logic [DATA_W-1:0] resp1_data;

    logic [DATA_W-1:0] alu_op1;
    logic [DATA_W-1:0] alu_op2;
    logic [SEL_W-1:0]  alu_sel;
    logic [DATA_W-1:0] alu_res;

    logic              prio;

    modport slave (
        input  req0_valid, req0_op1, req0_op2, req0_sel,
        input  req1_valid, req1_op1, req1_op2, req1_sel,
        input  resp0_ready, resp1_ready, alu_res,
        output req0_ready, req1_ready,
        output resp0_valid, resp0_data, resp1_valid, resp1_data,
        output alu_op1, alu_op2, alu_sel, prio
    );

    modport master (
        output req0_valid, req0_op1, req0_op2, req0_sel,
        output req1_valid, req1_op1, req1_op2, req1_sel,
        output resp0_ready, resp1_ready, alu_res,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp0_data, resp1_valid, resp1_data,
        input  alu_op1, alu_op2, alu_sel, prio
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter that shares one combinational ALU.
// The granted request drives the ALU in the same cycle. The result is captured
// into that requester's response slot, so a result appears one cycle after
// acceptance. Aggregate throughput is one operation per cycle.
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);
    logic              prio_q, prio_d;
    logic              resp0_valid_q, resp0_valid_d;
    logic              resp1_valid_q, resp1_valid_d;
    logic [DATA_W-1:0] resp0_data_q, resp0_data_d;
    logic [DATA_W-1:0] resp1_data_q, resp1_data_d;

    logic              elig0, elig1;
    logic              grant0, grant1;

    // Eligibility and grant. A full slot that is not draining blocks its
    // requester. Nothing is granted while reset is held.
    always_comb begin
        elig0  = bus.req0_valid && (!resp0_valid_q || bus.resp0_ready);
        elig1  = bus.req1_valid && (!resp1_valid_q || bus.resp1_ready);
        grant0 = rst_n && elig0 && (!elig1 || !prio_q);
        grant1 = rst_n && elig1 && (!elig0 ||  prio_q);
    end

    // Steer the granted operands onto the shared ALU. When idle, drive an ADD of zeros.
    always_comb begin
        bus.alu_op1 = '0;
        bus.alu_op2 = '0;
        bus.alu_sel = '0;
        if (grant0) begin
            bus.alu_op1 = bus.req0_op1;
            bus.alu_op2 = bus.req0_op2;
            bus.alu_sel = bus.req0_sel;
        end else if (grant1) begin
            bus.alu_op1 = bus.req1_op1;
            bus.alu_op2 = bus.req1_op2;
            bus.alu_sel = bus.req1_sel;
        end
    end

    // Next state. Priority flips away from the winner. A slot loads on grant,
    // which also covers a drain in the same cycle, and otherwise clears on drain.
    always_comb begin
        prio_d        = prio_q;
        resp0_valid_d = resp0_valid_q;
        resp1_valid_d = resp1_valid_q;
        resp0_data_d  = resp0_data_q;
        resp1_data_d  = resp1_data_q;

        if (grant0) begin
            prio_d = 1'b1;
        end else if (grant1) begin
            prio_d = 1'b0;
        end

        if (grant0) begin
            resp0_valid_d = 1'b1;
            resp0_data_d  = bus.alu_res;
        end else if (resp0_valid_q && bus.resp0_ready) begin
            resp0_valid_d = 1'b0;
        end

        if (grant1) begin
            resp1_valid_d = 1'b1;
            resp1_data_d  = bus.alu_res;
        end else if (resp1_valid_q && bus.resp1_ready) begin
            resp1_valid_d = 1'b0;
        end
    end

    // State registers. Asynchronous reset discards any pending responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q        <= 1'b0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            resp0_data_q  <= '0;
            resp1_data_q  <= '0;
        end else begin
            prio_q        <= prio_d;
            resp0_valid_q <= resp0_valid_d;
            resp1_valid_q <= resp1_valid_d;
            resp0_data_q  <= resp0_data_d;
            resp1_data_q  <= resp1_data_d;
        end
    end

    // Output drive.
    always_comb begin
        bus.req0_ready  = grant0;
        bus.req1_ready  = grant1;
        bus.resp0_valid = resp0_valid_q;
        bus.resp1_valid = resp1_valid_q;
        bus.resp0_data  = resp0_data_q;
        bus.resp1_data  = resp1_data_q;
        bus.prio        = prio_q;
    end
endmodule
